// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, synchronous flush and an
// optional two-entry skid buffer that keeps in_ready free of any path from out_ready.
module pipe_stage_reg #(
  parameter int unsigned           DATA_W    = 32,
  parameter logic [DATA_W-1:0]     RESET_VAL = '0,
  parameter int unsigned           SKID      = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);

  logic              main_v_q, main_v_d;
  logic              skid_v_q, skid_v_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [1:0]        count_q, count_d;
  logic              accept, drain;

  if (SKID != 0) begin : g_skid
    assign in_ready = ~skid_v_q;
  end else begin : g_noskid
    assign in_ready = ~main_v_q | out_ready;
  end

  assign accept    = in_valid & in_ready;
  assign drain     = main_v_q & out_ready;
  assign out_valid = main_v_q;
  assign out_data  = main_data_q;
  assign count     = count_q;

  always_comb begin
    main_v_d    = main_v_q;
    skid_v_d    = skid_v_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    // Flush only drops valid bits; payloads are left untouched.
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!main_v_q) begin
      if (accept) begin
        main_v_d    = 1'b1;
        main_data_d = in_data;
      end
    end else if (!skid_v_q) begin
      if (accept && drain) begin
        main_data_d = in_data;
      end else if (accept && (SKID != 0)) begin
        skid_v_d    = 1'b1;
        skid_data_d = in_data;
      end else if (drain) begin
        main_v_d = 1'b0;
      end
    end else if (drain) begin
      main_data_d = skid_data_q;
      skid_v_d    = 1'b0;
    end
    count_d = {1'b0, main_v_d} + {1'b0, skid_v_d};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_v_q    <= 1'b0;
      skid_v_q    <= 1'b0;
      main_data_q <= RESET_VAL;
      skid_data_q <= RESET_VAL;
      count_q     <= 2'd0;
    end else begin
      main_v_q    <= main_v_d;
      skid_v_q    <= skid_v_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
      count_q     <= count_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: skid and combinational variants share stimulus and are
// each checked every cycle against a queue-based model of the stage.
module tb_pipe_stage_reg;

  localparam int unsigned DW = 16;
  localparam logic [DW-1:0] RV = '0;

  logic          clk = 1'b0;
  logic          rst_n, flush, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic          in_ready1, out_valid1, in_ready0, out_valid0;
  logic [DW-1:0] out_data1, out_data0;
  logic [1:0]    count1, count0;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] q1[$];
  logic [DW-1:0] q0[$];
  logic [DW-1:0] last1, last0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .RESET_VAL(RV), .SKID(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .count(count1)
  );

  pipe_stage_reg #(.DATA_W(DW), .RESET_VAL(RV), .SKID(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .count(count0)
  );

  task chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered at a falling edge; returns at the next falling edge.
  task cycle(input logic rst, input logic fl, input logic iv, input logic [DW-1:0] din,
             input logic ordy, input bit en);
    bit acc1, dr1, acc0, dr0, rdy1, rdy0;
    rst_n = rst; flush = fl; in_valid = iv; in_data = din; out_ready = ordy;
    #1;
    rdy1 = q1.size() < 2;
    rdy0 = (q0.size() == 0) || ordy;
    acc1 = iv && rdy1;
    acc0 = iv && rdy0;
    dr1  = (q1.size() > 0) && ordy;
    dr0  = (q0.size() > 0) && ordy;
    if (en) begin
      chk("skid.in_ready", 32'(in_ready1), 32'(rdy1));
      chk("skid.out_valid", 32'(out_valid1), 32'(q1.size() > 0));
      chk("skid.out_data", 32'(out_data1), 32'((q1.size() > 0) ? q1[0] : last1));
      chk("skid.count", 32'(count1), 32'(q1.size()));
      chk("comb.in_ready", 32'(in_ready0), 32'(rdy0));
      chk("comb.out_valid", 32'(out_valid0), 32'(q0.size() > 0));
      chk("comb.out_data", 32'(out_data0), 32'((q0.size() > 0) ? q0[0] : last0));
      chk("comb.count", 32'(count0), 32'(q0.size()));
    end
    @(posedge clk);
    if (!rst) begin
      q1.delete(); q0.delete();
      last1 = RV; last0 = RV;
    end else if (fl) begin
      q1.delete(); q0.delete();
    end else begin
      if (dr1) void'(q1.pop_front());
      if (acc1) q1.push_back(din);
      if (dr0) void'(q0.pop_front());
      if (acc0) q0.push_back(din);
    end
    if (q1.size() > 0) last1 = q1[0];
    if (q0.size() > 0) last0 = q0[0];
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    last1 = RV; last0 = RV;
    @(negedge clk);

    // Reset held two cycles while flush and an offer are active
    cycle(1'b0, 1'b1, 1'b1, 16'hDEAD, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 16'hDEAD, 1'b0, 1'b1);
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; #1;
    chk("rst.out_valid", 32'(out_valid1), 32'd0);
    chk("rst.out_data", 32'(out_data1), 32'h0);
    chk("rst.count", 32'(count1), 32'd0);
    chk("rst.in_ready_skid", 32'(in_ready1), 32'd1);
    chk("rst.in_ready_comb", 32'(in_ready0), 32'd1);
    @(negedge clk);

    // Streaming with out_ready high
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 1'b0, 1'b1, DW'(i), 1'b1, 1'b1);
      chk("stream.out_data", 32'(out_data1), 32'(i));
      chk("stream.count", 32'(count1), 32'd1);
      chk("stream.in_ready", 32'(in_ready1), 32'd1);
    end
    cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);

    // Stall into skid, then drain in order
    cycle(1'b1, 1'b0, 1'b1, 16'hA, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 16'hB, 1'b0, 1'b1);
    chk("stall.count", 32'(count1), 32'd2);
    chk("stall.in_ready", 32'(in_ready1), 32'd0);
    chk("stall.out_data", 32'(out_data1), 32'hA);
    chk("stall.comb_count", 32'(count0), 32'd1);
    cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    chk("drain.out_data", 32'(out_data1), 32'hB);
    chk("drain.in_ready", 32'(in_ready1), 32'd1);
    cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    chk("drain.count", 32'(count1), 32'd0);

    // Flush in FULL with simultaneous drain and offer
    cycle(1'b1, 1'b0, 1'b1, 16'h1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 16'h2, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 16'hC, 1'b1, 1'b1);
    chk("flush.out_valid", 32'(out_valid1), 32'd0);
    chk("flush.count", 32'(count1), 32'd0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);

    // Combinational-ready variant under stall
    cycle(1'b1, 1'b0, 1'b1, 16'h5, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 16'h7, 1'b0, 1'b1);
    chk("comb.stall_count", 32'(count0), 32'd1);
    cycle(1'b1, 1'b0, 1'b1, 16'h6, 1'b1, 1'b1);
    chk("comb.next_data", 32'(out_data0), 32'h6);
    cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);

    // Reset while FULL
    cycle(1'b1, 1'b0, 1'b1, 16'h1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 16'h2, 1'b0, 1'b1);
    chk("mid.full_count", 32'(count1), 32'd2);
    cycle(1'b0, 1'b0, 1'b1, 16'h3, 1'b1, 1'b1);
    chk("mid.out_valid", 32'(out_valid1), 32'd0);
    chk("mid.count", 32'(count1), 32'd0);
    chk("mid.out_data", 32'(out_data1), 32'(RV));
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);

    // Random traffic with occasional flush and reset
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 60) != 0, ($urandom % 20) == 0, ($urandom % 4) != 0,
            DW'($urandom), ($urandom % 3) != 0, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with a valid/ready handshake, synchronous flush and an optional two-entry skid buffer. It generalises the fixed-field stage registers (IF/ID through MEM/WB) to an arbitrary-width payload, with per-stage backpressure and bubble tracking. Stages pack their fields (pc, ir, control word, ALU result, ...) into `in_data`. Stalls come from the downstream `out_ready`; squashes come from `flush`.

## Interface
- `DATA_W`, default 32: payload width in bits; must be ≥ 1.
- `RESET_VAL`, default `'0`: value loaded into both payload registers on reset. Width is `DATA_W`.
- `SKID`, default 1: selects the buffering mode.
  - 1: two-entry skid buffer; `in_ready` is registered.
  - 0: single entry; `in_ready` is combinational.
- `clk` input, 1: clock. All state changes on the rising edge.
- `rst_n` input, 1: reset. Synchronous, active-low.
- `flush` input, 1: squash all held entries.
- `in_valid` input, 1: upstream offers `in_data`.
- `in_ready` output, 1: the stage accepts this cycle.
- `in_data` input, `DATA_W`: upstream payload.
- `out_valid` output, 1: `out_data` is a valid entry.
- `out_ready` input, 1: downstream consumes this cycle.
- `out_data` output, `DATA_W`: head payload.
- `count` output, 2: number of valid entries (0–2).

## Operation
- **Handshake events:**
  - Accept = `in_valid & in_ready`.
  - Drain = `out_valid & out_ready`.
  - `in_data` is sampled only on an accept. `out_data` is meaningful only while `out_valid` = 1.
- **Storage:**
  - Main register (`main_v`, `main_d`) drives the outputs: `out_valid` = `main_v`, `out_data` = `main_d`.
  - Skid register (`skid_v`, `skid_d`) exists only when `SKID` = 1.
- **States** (`SKID` = 1), as (`main_v`, `skid_v`):
  - EMPTY = (0,0)
  - ONE = (1,0)
  - FULL = (1,1)
  - (0,1) is illegal and never reached.
- **Transitions** (no flush):
  - EMPTY: accept → ONE, `main_d` ← `in_data`. Otherwise stay.
  - ONE, accept & drain: stay ONE, `main_d` ← `in_data`.
  - ONE, accept & !drain: → FULL, `skid_d` ← `in_data`.
  - ONE, !accept & drain: → EMPTY.
  - ONE, neither: hold.
  - FULL: no accept possible. Drain → ONE, `main_d` ← `skid_d`. Otherwise hold.
- **`in_ready`:**
  - `SKID` = 1: `in_ready` = `!skid_v`. It is a pure register output with no combinational path from `out_ready`.
  - `SKID` = 0: `in_ready` = `!main_v | out_ready`. States are EMPTY and ONE only; `count` ≤ 1.
- **Flush:**
  - The next edge clears `main_v` and `skid_v`.
  - An accept in the flush cycle is discarded.
  - A drain in the flush cycle still counts as consumed by downstream.
  - Payload registers are not cleared by flush.
  - `in_ready` is not masked during flush.
- **Reset:**
  - Reset dominates flush and all handshakes, at any point mid-operation.
  - `main_d` = `skid_d` = `RESET_VAL`; `main_v` = `skid_v` = 0.
- **Data hold:** payload registers load only on the listed transitions; they never load while invalid.
- **`count`:** `main_v + skid_v`, registered alongside the valid bits.

## Timing
- **After the first rising edge with `rst_n` = 0:**
  - `out_valid` = 0, `out_data` = `RESET_VAL`, `count` = 0.
  - `in_ready` = 1 in both modes.
- **Latency:** accept at edge N → `out_valid` = 1 with that payload from after edge N until drained. One cycle of latency.
- **Throughput:** one transfer per cycle while `out_ready` = 1, in both modes.
- **Stall:**
  - `SKID` = 1: `out_ready` = 0 in ONE with `in_valid` = 1 → FULL next cycle, `in_ready` = 0 from the following cycle. At most one extra entry is absorbed.
  - `SKID` = 0: `in_ready` falls in the same cycle as `out_ready`.
- **FULL drain:** `in_ready` returns to 1 the cycle after the drain edge.
- **Order:** FIFO order is preserved across skid transfers; no duplication and no loss except by flush.
- **Simultaneous flush + drain + accept in FULL:** next state is EMPTY; `count` = 0.

## Test plan
1. **Reset:** hold `rst_n` = 0 for 2 cycles while driving `in_valid` = 1, `in_data` = 0xDEAD, `flush` = 1 → `out_valid` = 0, `out_data` = `RESET_VAL` (0), `count` = 0, `in_ready` = 1 after release.
2. **Streaming:** `SKID` = 1, `out_ready` = 1, push 0x1..0x8 back-to-back → `out_data` shows 0x1..0x8 on consecutive cycles, each one cycle after its accept; `in_ready` stays 1; `count` = 1 throughout.
3. **Stall and skid:** push 0xA then 0xB with `out_ready` = 0.
   - Expect `count` = 2, `in_ready` = 0, `out_data` = 0xA.
   - Raise `out_ready` → 0xA, then 0xB, drain in order; `in_ready` returns to 1 the cycle after the first drain.
4. **Flush in FULL:** in FULL state, assert `flush` with `in_valid` = 1, `in_data` = 0xC → `out_valid` = 0 and `count` = 0 next cycle; 0xC never appears at the output.
5. **Combinational mode:** `SKID` = 0, hold `out_ready` = 0 with one entry 0x5 → `in_ready` = 0 in the same cycle and `count` never exceeds 1; raise `out_ready` with `in_valid` = 1, `in_data` = 0x6 → `in_ready` = 1 that cycle and `out_data` = 0x6 next.
6. **Mid-stream reset:** in FULL holding 0x1 and 0x2, drive `rst_n` = 0 for one cycle → `out_valid` = 0, `count` = 0, `out_data` = `RESET_VAL`, and neither 0x1 nor 0x2 is emitted afterwards.
